// File: rtl/conv_pkg.sv
// Shared definitions for the Conv datapath and its pooling stage:
// width helpers, the pooling FSM state type and a signed max.
package conv_pkg;

    // Wide enough to hold any OUTW-bit operand of the max helper.
    localparam int MAX_W = 128;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Result width of a MAXK x MAXK signed INW-bit dot product plus bias headroom.
    function automatic int calc_outw(input int inw, input int maxk);
        logic [127:0] span;
        span = 128'(maxk) * 128'(maxk) * (128'd1 << (2 * inw - 2)) + (128'd1 << (inw - 1));
        return $clog2(span) + 1;
    endfunction

    // Width needed to carry a kernel size of 0..maxk.
    function automatic int calc_kbits(input int maxk);
        return $clog2(maxk + 1);
    endfunction

    // Signed maximum; callers sign-extend to MAX_W and truncate the result back.
    function automatic logic signed [MAX_W-1:0] smax(input logic signed [MAX_W-1:0] a,
                                                     input logic signed [MAX_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/conv_pool_relu_if.sv
// Stream bundle between the Conv output FIFO, the pooling stage and its consumer.
// The slave modport is the pooling block; the master modport is its environment.
interface conv_pool_relu_if #(
    parameter int W  = 40,
    parameter int KW = 3
);
    logic [KW-1:0]       IN_K;
    logic signed [W-1:0] INPUT_TDATA;
    logic                INPUT_TVALID;
    logic                INPUT_TREADY;
    logic signed [W-1:0] OUTPUT_TDATA;
    logic                OUTPUT_TVALID;
    logic                OUTPUT_TREADY;
    logic                OUTPUT_TLAST;

    modport master (
        output IN_K, INPUT_TDATA, INPUT_TVALID, OUTPUT_TREADY,
        input  INPUT_TREADY, OUTPUT_TDATA, OUTPUT_TVALID, OUTPUT_TLAST
    );

    modport slave (
        input  IN_K, INPUT_TDATA, INPUT_TVALID, OUTPUT_TREADY,
        output INPUT_TREADY, OUTPUT_TDATA, OUTPUT_TVALID, OUTPUT_TLAST
    );
endinterface

// File: rtl/pool_linebuf.sv
// Line buffer of horizontal partial maxima from the even row of each pooled pair.
// One write port, one combinational read port, no reset: every entry is written
// on the even row before the odd row reads it.
module pool_linebuf #(
    parameter int DEPTH = 4,
    parameter int W     = 40,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       wr_addr,
    input  logic signed [W-1:0] wr_data,
    input  logic [AW-1:0]       rd_addr,
    output logic signed [W-1:0] rd_data
);

    logic signed [W-1:0] mem [DEPTH];

    // Store one partial maximum per pooled column.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/conv_pool_relu.sv
// Streaming 2x2 stride-2 max-pool behind the Conv output FIFO.
// Optional ReLU on the pooled value is enabled by defining POOL_RELU_EN.
module conv_pool_relu
    import conv_pkg::*;
#(
    parameter int INW  = 18,
    parameter int R    = 8,
    parameter int C    = 8,
    parameter int MAXK = 5
) (
    input  logic           clk,
    input  logic           reset,
    conv_pool_relu_if.slave bus
);

    localparam int OUTW     = calc_outw(INW, MAXK);
    localparam int K_BITS   = calc_kbits(MAXK);
    localparam int LB_DEPTH = C / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam int DW       = $clog2(((R > C) ? R : C) + 1) + 1;

    state_t                 state_reg;
    logic [K_BITS-1:0]      kq_reg;
    logic [K_BITS-1:0]      k_cur;
    logic [DW-1:0]          row_reg;
    logic [DW-1:0]          col_reg;
    logic [DW-1:0]          rq;
    logic [DW-1:0]          cq;
    logic [DW-1:0]          rp;
    logic [DW-1:0]          cp;
    logic signed [OUTW-1:0] h_reg;
    logic signed [OUTW-1:0] x;
    logic signed [OUTW-1:0] lb_rd;
    logic signed [OUTW-1:0] hx_max;
    logic signed [OUTW-1:0] lbx_max;
    logic signed [OUTW-1:0] pooled;
    logic signed [OUTW-1:0] out_data_reg;
    logic                   out_valid_reg;
    logic                   out_last_reg;
    logic                   accept;
    logic                   in_pool;
    logic                   row_odd;
    logic                   col_odd;
    logic                   last_col;
    logic                   last_beat;
    logic                   lb_we;
    logic [LB_AW-1:0]       lb_addr;

    // The first beat of a frame is processed while still in IDLE, so it sees IN_K directly.
    assign k_cur = (state_reg == IDLE) ? bus.IN_K : kq_reg;
    assign rq    = DW'(R + 1) - DW'(k_cur);
    assign cq    = DW'(C + 1) - DW'(k_cur);
    assign rp    = {rq[DW-1:1], 1'b0};
    assign cp    = {cq[DW-1:1], 1'b0};

    assign x         = bus.INPUT_TDATA;
    assign accept    = bus.INPUT_TVALID && bus.INPUT_TREADY;
    assign in_pool   = (row_reg < rp) && (col_reg < cp);
    assign row_odd   = row_reg[0];
    assign col_odd   = col_reg[0];
    assign last_col  = (col_reg == cq - DW'(1));
    assign last_beat = last_col && (row_reg == rq - DW'(1));

    assign hx_max  = OUTW'(smax(MAX_W'(h_reg), MAX_W'(x)));
    assign lbx_max = OUTW'(smax(MAX_W'(lb_rd), MAX_W'(x)));

`ifdef POOL_RELU_EN
    assign pooled = hx_max[OUTW-1] ? '0 : hx_max;
`else
    assign pooled = hx_max;
`endif

    assign lb_addr = LB_AW'(col_reg >> 1);
    assign lb_we   = accept && in_pool && !row_odd && col_odd;

    pool_linebuf #(
        .DEPTH (LB_DEPTH),
        .W     (OUTW)
    ) u_linebuf (
        .clk     (clk),
        .we      (lb_we),
        .wr_addr (lb_addr),
        .wr_data (hx_max),
        .rd_addr (lb_addr),
        .rd_data (lb_rd)
    );

    // Frame FSM, raster counters, horizontal hold register and output register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            kq_reg        <= '0;
            row_reg       <= '0;
            col_reg       <= '0;
            h_reg         <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            if (out_valid_reg && bus.OUTPUT_TREADY) begin
                out_valid_reg <= 1'b0;
            end
            // A beat is only accepted when the output register is free or draining,
            // so a reload here never overwrites an untransferred result.
            if (accept) begin
                if (state_reg == IDLE) begin
                    kq_reg <= bus.IN_K;
                end
                if (last_beat) begin
                    row_reg   <= '0;
                    col_reg   <= '0;
                    state_reg <= IDLE;
                end else begin
                    state_reg <= RUN;
                    if (last_col) begin
                        col_reg <= '0;
                        row_reg <= row_reg + DW'(1);
                    end else begin
                        col_reg <= col_reg + DW'(1);
                    end
                end
                // Trailing odd row/column beats fall outside in_pool and are dropped.
                if (in_pool) begin
                    if (!row_odd && !col_odd) begin
                        h_reg <= x;
                    end else if (row_odd && !col_odd) begin
                        h_reg <= lbx_max;
                    end else if (row_odd && col_odd) begin
                        out_data_reg  <= pooled;
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= (row_reg == rp - DW'(1)) && (col_reg == cp - DW'(1));
                    end
                end
            end
        end
    end

    assign bus.INPUT_TREADY  = !out_valid_reg || bus.OUTPUT_TREADY;
    assign bus.OUTPUT_TDATA  = out_data_reg;
    assign bus.OUTPUT_TVALID = out_valid_reg;
    assign bus.OUTPUT_TLAST  = out_last_reg;

endmodule

// File: tb/tb_conv_pool_relu.sv
// Self-checking bench for conv_pool_relu: directed frames plus random frames
// with random valid/ready throttling, checked against a 2-D max-pool model.
module tb_conv_pool_relu;
    import conv_pkg::*;

    localparam int INW  = 18;
    localparam int R    = 8;
    localparam int C    = 8;
    localparam int MAXK = 8;
    localparam int OUTW = calc_outw(INW, MAXK);
    localparam int KB   = calc_kbits(MAXK);

    typedef logic signed [OUTW-1:0] data_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    conv_pool_relu_if #(.W(OUTW), .KW(KB)) bus ();

    conv_pool_relu #(
        .INW  (INW),
        .R    (R),
        .C    (C),
        .MAXK (MAXK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    data_t frame_q[$];
    data_t exp_d[$];
    bit    exp_l[$];

    task automatic check(input string tag, input longint got, input longint want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Reference: each pooled cell is the max of its 2x2 window of the Rq x Cq frame.
    function automatic void build_expect(input int k);
        int    rq;
        int    cq;
        data_t m;
        data_t v;
        rq = R - k + 1;
        cq = C - k + 1;
        exp_d.delete();
        exp_l.delete();
        for (int i = 0; i < rq / 2; i++) begin
            for (int j = 0; j < cq / 2; j++) begin
                m = frame_q[(2 * i) * cq + 2 * j];
                for (int di = 0; di < 2; di++) begin
                    for (int dj = 0; dj < 2; dj++) begin
                        v = frame_q[(2 * i + di) * cq + 2 * j + dj];
                        if (v > m) m = v;
                    end
                end
`ifdef POOL_RELU_EN
                if (m < 0) m = '0;
`endif
                exp_d.push_back(m);
                exp_l.push_back((i == rq / 2 - 1) && (j == cq / 2 - 1));
            end
        end
    endfunction

    function automatic void make_ramp(input int k, input bit neg);
        int n;
        n = (R - k + 1) * (C - k + 1);
        frame_q.delete();
        for (int i = 0; i < n; i++) begin
            frame_q.push_back(neg ? data_t'(-(i + 1)) : data_t'(i));
        end
    endfunction

    function automatic void make_rand(input int k);
        int    n;
        int    s;
        data_t v;
        n = (R - k + 1) * (C - k + 1);
        frame_q.delete();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                v = data_t'({$urandom, $urandom});
            end else begin
                s = int'($urandom_range(0, 200)) - 100;
                v = data_t'(s);
            end
            frame_q.push_back(v);
        end
    endfunction

    // Scenario-1 results written out by hand (6x6 ramp 0..35).
    function automatic void load_ramp6_expect();
        int vals[9];
        vals = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
        exp_d.delete();
        exp_l.delete();
        for (int i = 0; i < 9; i++) begin
            exp_d.push_back(data_t'(vals[i]));
            exp_l.push_back(i == 8);
        end
    endfunction

    // Drive frame_q and check every output beat; rmode 0 = always ready,
    // 1 = random ready, 2 = ready held low for 5 cycles at the first output.
    task automatic run_frame(input int k, input int limit, input int rmode, input int vprob);
        int    total;
        int    nexp;
        int    sent;
        int    cyc;
        int    outs;
        int    stall;
        bit    stalled;
        bit    stall_now;
        bit    done;
        bit    prev_fire;
        bit    in_fire;
        bit    out_fire;
        bit    hold_pend;
        data_t hd;
        logic  hl;
        data_t ed;
        bit    el;
        total = frame_q.size();
        if (limit > total) limit = total;
        nexp      = exp_d.size();
        sent      = 0;
        cyc       = 0;
        outs      = 0;
        stall     = 0;
        stalled   = 0;
        done      = 0;
        prev_fire = 0;
        hold_pend = 0;
        hd        = '0;
        hl        = 1'b0;
        bus.IN_K  = KB'(k);
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (hold_pend) begin
                check("hold_valid", longint'(bus.OUTPUT_TVALID), 1);
                check("hold_data", longint'(bus.OUTPUT_TDATA), longint'(hd));
                check("hold_last", longint'(bus.OUTPUT_TLAST), longint'(hl));
            end
            if (prev_fire) bus.INPUT_TVALID = 1'b0;
            if (!bus.INPUT_TVALID && sent < limit && int'($urandom_range(0, 99)) < vprob) begin
                bus.INPUT_TVALID = 1'b1;
                bus.INPUT_TDATA  = frame_q[sent];
            end
            stall_now = 0;
            case (rmode)
                0: bus.OUTPUT_TREADY = 1'b1;
                1: bus.OUTPUT_TREADY = ($urandom_range(0, 99) < 70);
                default: begin
                    if (!stalled && bus.OUTPUT_TVALID) begin
                        stalled = 1;
                        stall   = 5;
                    end
                    if (stall > 0) begin
                        stall_now = 1;
                        stall--;
                        bus.OUTPUT_TREADY = 1'b0;
                    end else begin
                        bus.OUTPUT_TREADY = 1'b1;
                    end
                end
            endcase
            #1;
            check("in_ready", longint'(bus.INPUT_TREADY),
                  longint'(!bus.OUTPUT_TVALID || bus.OUTPUT_TREADY));
            if (stall_now) check("stall_in_ready", longint'(bus.INPUT_TREADY), 0);
            in_fire  = bus.INPUT_TVALID && bus.INPUT_TREADY;
            out_fire = bus.OUTPUT_TVALID && bus.OUTPUT_TREADY;
            if (out_fire) begin
                outs++;
                if (exp_d.size() > 0) begin
                    ed = exp_d.pop_front();
                    el = exp_l.pop_front();
                    $display("[TB] k=%0d out=%0d last=%0d want=%0d/%0d", k,
                             bus.OUTPUT_TDATA, bus.OUTPUT_TLAST, ed, el);
                    check("out_data", longint'(bus.OUTPUT_TDATA), longint'(ed));
                    check("out_last", longint'(bus.OUTPUT_TLAST), longint'(el));
                end else begin
                    check("extra_out", 1, 0);
                end
            end
            hold_pend = bus.OUTPUT_TVALID && !bus.OUTPUT_TREADY;
            hd        = bus.OUTPUT_TDATA;
            hl        = bus.OUTPUT_TLAST;
            if (limit == total && sent == total && exp_d.size() == 0 && !bus.OUTPUT_TVALID) begin
                done = 1;
            end
            if (!done) begin
                @(posedge clk);
                if (in_fire) sent++;
                prev_fire = in_fire;
                if (limit < total && sent == limit) done = 1;
            end
        end
        if (!done) check("timeout", 0, 1);
        if (limit == total) check("out_count", outs, nexp);
    endtask

    initial begin
        int k;
        bus.IN_K          = KB'(3);
        bus.INPUT_TDATA   = '0;
        bus.INPUT_TVALID  = 1'b0;
        bus.OUTPUT_TREADY = 1'b1;
        reset             = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_valid", longint'(bus.OUTPUT_TVALID), 0);
        check("rst_data", longint'(bus.OUTPUT_TDATA), 0);
        check("rst_last", longint'(bus.OUTPUT_TLAST), 0);
        check("rst_in_ready", longint'(bus.INPUT_TREADY), 1);

        // 6x6 ramp, always ready.
        make_ramp(3, 0);
        load_ramp6_expect();
        run_frame(3, 1000, 0, 100);

        // 6x6 negative ramp.
        make_ramp(3, 1);
        build_expect(3);
        run_frame(3, 1000, 0, 100);

        // 5x5 ramp: trailing row and column discarded.
        make_ramp(4, 0);
        build_expect(4);
        run_frame(4, 1000, 0, 100);

        // 1x1 frame: one beat, no output; then a normal frame.
        make_ramp(8, 0);
        build_expect(8);
        run_frame(8, 1000, 0, 100);
        make_ramp(3, 0);
        load_ramp6_expect();
        run_frame(3, 1000, 0, 100);

        // Downstream stall of 5 cycles on the first output.
        make_ramp(3, 0);
        load_ramp6_expect();
        run_frame(3, 1000, 2, 100);

        // Reset after 20 beats, then a fresh frame.
        make_ramp(3, 0);
        build_expect(3);
        run_frame(3, 20, 0, 100);
        @(negedge clk);
        reset            = 1'b0;
        bus.INPUT_TVALID = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_valid", longint'(bus.OUTPUT_TVALID), 0);
        check("midrst_last", longint'(bus.OUTPUT_TLAST), 0);
        check("midrst_in_ready", longint'(bus.INPUT_TREADY), 1);
        make_ramp(3, 0);
        load_ramp6_expect();
        run_frame(3, 1000, 0, 100);

        // Random frames with random kernel sizes and throttling on both sides.
        for (int f = 0; f < 10; f++) begin
            k = int'($urandom_range(1, 8));
            make_rand(k);
            build_expect(k);
            run_frame(k, 1000, 1, 70);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
